// File: rtl/kanagawa_quad_port_memory_arbiter.sv
// +----------------------------------------------------------------------------+
// | kanagawa_quad_port_memory_arbiter                                          |
// | Shares one 2W/2R memory among NUM_REQ requesters.                          |
// | Two round-robin arbiters drive the memory ports. A tag pipeline routes     |
// | each read response back to the requester that issued it.                   |
// | Optional stall counters: define KANAGAWA_QPM_ARBITER_STALL_STATS_EN.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module kanagawa_quad_port_memory_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            wr_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_in,
    output logic [NUM_REQ-1:0]            wr_ready_out,
    input  logic [NUM_REQ-1:0]            rd_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_in,
    output logic [NUM_REQ-1:0]            rd_ready_out,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_out,
    output logic [1:0]                    mem_wren_out,
    output logic [2*ADDR_WIDTH-1:0]       mem_write_addr_out,
    output logic [2*DATA_WIDTH-1:0]       mem_data_out,
    output logic [1:0]                    mem_rden_out,
    output logic [2*ADDR_WIDTH-1:0]       mem_read_addr_out,
    input  logic [2*DATA_WIDTH-1:0]       mem_q_in,
    output logic [NUM_REQ*16-1:0]         stall_count_out
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base,
                                                  input int ofs);
        int v_sum;
        v_sum = int'(base) + ofs;
        if (v_sum >= NUM_REQ) begin
            v_sum = v_sum - NUM_REQ;
        end
        return v_sum[c_IDX_W-1:0];
    endfunction

    logic [c_IDX_W-1:0] r_wr_ptr;
    logic [c_IDX_W-1:0] r_rd_ptr;
    logic [c_IDX_W-1:0] w_wr_ptr_nxt;
    logic [c_IDX_W-1:0] w_rd_ptr_nxt;

    logic [1:0]         w_wr_vld;
    logic [c_IDX_W-1:0] w_wr_idx [2];
    logic [c_IDX_W-1:0] w_wr_scan;
    logic [1:0]         w_rd_vld;
    logic [c_IDX_W-1:0] w_rd_idx [2];
    logic [c_IDX_W-1:0] w_rd_scan;

    logic [1:0]         w_pop_vld;
    logic [c_IDX_W-1:0] w_pop_id [2];

    // Write scan: port 1 skips anyone targeting port 0's address; they retry later.
    always_comb begin
        w_wr_vld    = 2'b00;
        w_wr_idx[0] = '0;
        w_wr_idx[1] = '0;
        w_wr_scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_wr_scan = f_wrap(r_wr_ptr, k);
            if (!rst && wr_valid_in[w_wr_scan]) begin
                if (!w_wr_vld[0]) begin
                    w_wr_vld[0] = 1'b1;
                    w_wr_idx[0] = w_wr_scan;
                end else if (!w_wr_vld[1] &&
                             (wr_addr_in[int'(w_wr_scan)*ADDR_WIDTH +: ADDR_WIDTH] !=
                              wr_addr_in[int'(w_wr_idx[0])*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    w_wr_vld[1] = 1'b1;
                    w_wr_idx[1] = w_wr_scan;
                end
            end
        end
    end

    always_comb begin
        w_rd_vld    = 2'b00;
        w_rd_idx[0] = '0;
        w_rd_idx[1] = '0;
        w_rd_scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rd_scan = f_wrap(r_rd_ptr, k);
            if (!rst && rd_valid_in[w_rd_scan]) begin
                if (!w_rd_vld[0]) begin
                    w_rd_vld[0] = 1'b1;
                    w_rd_idx[0] = w_rd_scan;
                end else if (!w_rd_vld[1]) begin
                    w_rd_vld[1] = 1'b1;
                    w_rd_idx[1] = w_rd_scan;
                end
            end
        end
    end

    always_comb begin
        wr_ready_out       = '0;
        rd_ready_out       = '0;
        mem_wren_out       = w_wr_vld;
        mem_rden_out       = w_rd_vld;
        mem_write_addr_out = '0;
        mem_data_out       = '0;
        mem_read_addr_out  = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_wr_vld[p]) begin
                wr_ready_out[w_wr_idx[p]] = 1'b1;
                mem_write_addr_out[p*ADDR_WIDTH +: ADDR_WIDTH] =
                    wr_addr_in[int'(w_wr_idx[p])*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data_out[p*DATA_WIDTH +: DATA_WIDTH] =
                    wr_data_in[int'(w_wr_idx[p])*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_rd_vld[p]) begin
                rd_ready_out[w_rd_idx[p]] = 1'b1;
                mem_read_addr_out[p*ADDR_WIDTH +: ADDR_WIDTH] =
                    rd_addr_in[int'(w_rd_idx[p])*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Pointer moves past the last requester granted this cycle.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        if (w_wr_vld[1]) begin
            w_wr_ptr_nxt = f_wrap(w_wr_idx[1], 1);
        end else if (w_wr_vld[0]) begin
            w_wr_ptr_nxt = f_wrap(w_wr_idx[0], 1);
        end
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_rd_vld[1]) begin
            w_rd_ptr_nxt = f_wrap(w_rd_idx[1], 1);
        end else if (w_rd_vld[0]) begin
            w_rd_ptr_nxt = f_wrap(w_rd_idx[0], 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            logic [READ_LATENCY-1:0] r_tag_v;
            logic [c_IDX_W-1:0]      r_tag_id [READ_LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_v <= '0;
                end else begin
                    r_tag_v[0] <= w_rd_vld[p];
                    for (int s = 1; s < READ_LATENCY; s++) begin
                        r_tag_v[s] <= r_tag_v[s-1];
                    end
                end
                r_tag_id[0] <= w_rd_idx[p];
                for (int s = 1; s < READ_LATENCY; s++) begin
                    r_tag_id[s] <= r_tag_id[s-1];
                end
            end

            assign w_pop_vld[p] = r_tag_v[READ_LATENCY-1];
            assign w_pop_id[p]  = r_tag_id[READ_LATENCY-1];
        end
    endgenerate

    // Both ports were issued in the same cycle to distinct ids, so no collision here.
    always_comb begin
        rsp_valid_out = '0;
        rsp_data_out  = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_pop_vld[p]) begin
                rsp_valid_out[w_pop_id[p]] = 1'b1;
                rsp_data_out[int'(w_pop_id[p])*DATA_WIDTH +: DATA_WIDTH] =
                    mem_q_in[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef KANAGAWA_QPM_ARBITER_STALL_STATS_EN
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
            logic [15:0] r_cnt;
            logic        w_stall;

            assign w_stall = (wr_valid_in[i] & ~wr_ready_out[i]) |
                             (rd_valid_in[i] & ~rd_ready_out[i]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_stall && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign stall_count_out[i*16 +: 16] = r_cnt;
        end
    endgenerate
`else
    assign stall_count_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kanagawa_quad_port_memory_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_kanagawa_quad_port_memory_arbiter                                       |
// | Directed bench with a 2W/2R latency-2 memory model.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kanagawa_quad_port_memory_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int RL = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    wr_valid_in;
    logic [NR*AW-1:0] wr_addr_in;
    logic [NR*DW-1:0] wr_data_in;
    logic [NR-1:0]    wr_ready_out;
    logic [NR-1:0]    rd_valid_in;
    logic [NR*AW-1:0] rd_addr_in;
    logic [NR-1:0]    rd_ready_out;
    logic [NR-1:0]    rsp_valid_out;
    logic [NR*DW-1:0] rsp_data_out;
    logic [1:0]       mem_wren_out;
    logic [2*AW-1:0]  mem_write_addr_out;
    logic [2*DW-1:0]  mem_data_out;
    logic [1:0]       mem_rden_out;
    logic [2*AW-1:0]  mem_read_addr_out;
    logic [2*DW-1:0]  mem_q_in;
    logic [NR*16-1:0] stall_count_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kanagawa_quad_port_memory_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_ready_out(wr_ready_out),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in), .rd_ready_out(rd_ready_out),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .mem_wren_out(mem_wren_out), .mem_write_addr_out(mem_write_addr_out),
        .mem_data_out(mem_data_out), .mem_rden_out(mem_rden_out),
        .mem_read_addr_out(mem_read_addr_out), .mem_q_in(mem_q_in),
        .stall_count_out(stall_count_out)
    );

    // Memory stand-in: registered address plus registered output, old data on collision.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] q1 [2];
    logic [DW-1:0] q2 [2];

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (mem_wren_out[p]) mem[mem_write_addr_out[p*AW +: AW]] <= mem_data_out[p*DW +: DW];
            if (mem_rden_out[p]) q1[p] <= mem[mem_read_addr_out[p*AW +: AW]];
            q2[p] <= q1[p];
        end
    end
    assign mem_q_in = {q2[1], q2[0]};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid_in[r]         = 1'b1;
        wr_addr_in[r*AW +: AW] = a;
        wr_data_in[r*DW +: DW] = d;
    endtask

    task automatic set_rd(input int r, input logic [AW-1:0] a);
        rd_valid_in[r]         = 1'b1;
        rd_addr_in[r*AW +: AW] = a;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] fdata [NR];
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rsp;

        rst = 1'b1;
        wr_valid_in = '0; wr_addr_in = '0; wr_data_in = '0;
        rd_valid_in = '0; rd_addr_in = '0;
        step();

        // Requests during reset must not be granted.
        wr_valid_in = '1;
        rd_valid_in = '1;
        mid();
        chk("rst_wr_ready", 64'(wr_ready_out), 64'h0);
        chk("rst_rd_ready", 64'(rd_ready_out), 64'h0);
        chk("rst_enables", 64'({mem_wren_out, mem_rden_out}), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid_out), 64'h0);
        chk("rst_rsp_data_lo", rsp_data_out[63:0], 64'h0);
        wr_valid_in = '0;
        rd_valid_in = '0;
        step();
        rst = 1'b0;

        mid();
        chk("idle_enables", 64'({mem_wren_out, mem_rden_out}), 64'h0);
        step();

        // Two writes, distinct addresses.
        set_wr(0, 10'h005, 32'hAAAA);
        set_wr(2, 10'h006, 32'hBBBB);
        mid();
        chk("w2_ready", 64'(wr_ready_out), 64'b0101);
        chk("w2_wren", 64'(mem_wren_out), 64'b11);
        chk("w2_addr", 64'(mem_write_addr_out), 64'({10'h006, 10'h005}));
        chk("w2_data", 64'(mem_data_out), {32'hBBBB, 32'hAAAA});
        step();
        wr_valid_in = '0;

        // wr_ptr is 3: req3 takes port 0, scan wraps to req0 for port 1.
        set_wr(0, 10'h020, 32'h1);
        set_wr(3, 10'h021, 32'h2);
        mid();
        chk("wrap_ready", 64'(wr_ready_out), 64'b1001);
        chk("wrap_addr", 64'(mem_write_addr_out), 64'({10'h020, 10'h021}));
        chk("wrap_data", 64'(mem_data_out), {32'h1, 32'h2});
        step();
        wr_valid_in = '0;

        set_wr(3, 10'h022, 32'h3);
        mid();
        chk("w3_ready", 64'(wr_ready_out), 64'b1000);
        step();
        wr_valid_in = '0;

        // Same-address conflict from wr_ptr 0.
        set_wr(1, 10'h010, 32'h1111);
        set_wr(3, 10'h010, 32'h3333);
        mid();
        chk("conf1_ready", 64'(wr_ready_out), 64'b0010);
        chk("conf1_wren", 64'(mem_wren_out), 64'b01);
        chk("conf1_data", 64'(mem_data_out[DW-1:0]), 64'h1111);
        step();
        wr_valid_in[1] = 1'b0;
        mid();
        chk("conf2_ready", 64'(wr_ready_out), 64'b1000);
        chk("conf2_wren", 64'(mem_wren_out), 64'b01);
        chk("conf2_addr", 64'(mem_write_addr_out[AW-1:0]), 64'h010);
        chk("conf2_data", 64'(mem_data_out[DW-1:0]), 64'h3333);
        step();
        wr_valid_in = '0;

        // Routing: single read by req3.
        set_rd(3, 10'h005);
        mid();
        chk("r3_ready", 64'(rd_ready_out), 64'b1000);
        chk("r3_rden", 64'(mem_rden_out), 64'b01);
        chk("r3_addr", 64'(mem_read_addr_out[AW-1:0]), 64'h005);
        step();
        rd_valid_in = '0;
        mid();
        chk("r3_early", 64'(rsp_valid_out), 64'h0);
        step();
        mid();
        chk("r3_rsp_valid", 64'(rsp_valid_out), 64'b1000);
        chk("r3_rsp_data", 64'(rsp_data_out[3*DW +: DW]), 64'hAAAA);
        chk("r3_rsp_other", rsp_data_out[63:0], 64'h0);
        step();

        // Two reads in one cycle, rd_ptr back at 0.
        set_rd(1, 10'h010);
        set_rd(2, 10'h006);
        mid();
        chk("r12_ready", 64'(rd_ready_out), 64'b0110);
        chk("r12_addr", 64'(mem_read_addr_out), 64'({10'h006, 10'h010}));
        step();
        rd_valid_in = '0;
        step();
        mid();
        chk("r12_rsp_valid", 64'(rsp_valid_out), 64'b0110);
        chk("r12_rsp_d1", 64'(rsp_data_out[1*DW +: DW]), 64'h3333);
        chk("r12_rsp_d2", 64'(rsp_data_out[2*DW +: DW]), 64'hBBBB);
        chk("r12_rsp_other", {rsp_data_out[3*DW +: DW], rsp_data_out[DW-1:0]}, 64'h0);
        step();

        // Reset with reads in flight (rd_ptr 3 -> req0 port 0, req1 port 1).
        set_rd(0, 10'h005);
        set_rd(1, 10'h006);
        mid();
        chk("rf_ready", 64'(rd_ready_out), 64'b0011);
        step();
        rd_valid_in = '0;
        rst = 1'b1;
        mid();
        chk("rf_rsp_in_rst", 64'(rsp_valid_out), 64'h0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk($sformatf("rf_rsp_after%0d", c), 64'(rsp_valid_out), 64'h0);
            step();
        end

        // Fairness: all four read continuously for four cycles.
        fdata[0] = 32'hAAAA; fdata[1] = 32'hBBBB; fdata[2] = 32'h3333; fdata[3] = 32'h2;
        set_rd(0, 10'h005);
        set_rd(1, 10'h006);
        set_rd(2, 10'h010);
        set_rd(3, 10'h021);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rd_valid_in = '0;
            mid();
            exp_rdy = (c < 4) ? ((c % 2 == 0) ? 4'b0011 : 4'b1100) : 4'b0000;
            exp_rsp = (c >= 2 && c < 6) ? ((c % 2 == 0) ? 4'b0011 : 4'b1100) : 4'b0000;
            chk($sformatf("fair_rdy%0d", c), 64'(rd_ready_out), 64'(exp_rdy));
            chk($sformatf("fair_rsp%0d", c), 64'(rsp_valid_out), 64'(exp_rsp));
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("fair_d%0d_%0d", c, i), 64'(rsp_data_out[i*DW +: DW]),
                    exp_rsp[i] ? 64'(fdata[i]) : 64'h0);
            end
            step();
        end

        // Starvation pattern: req0/req3 win every cycle, req1/req2 stall on the shared address.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_wr(0, 10'h100, 32'h10);
        set_wr(1, 10'h100, 32'h11);
        set_wr(2, 10'h100, 32'h12);
        set_wr(3, 10'h101, 32'h13);
        for (int c = 0; c < 5; c++) begin
            mid();
            chk($sformatf("starve_rdy%0d", c), 64'(wr_ready_out), 64'b1001);
            step();
        end
        mid();
`ifdef KANAGAWA_QPM_ARBITER_STALL_STATS_EN
        chk("stall_req2_5", 64'(stall_count_out[2*16 +: 16]), 64'd5);
        chk("stall_req0_0", 64'(stall_count_out[15:0]), 64'd0);
        for (int c = 0; c < 70000; c++) step();
        mid();
        chk("stall_req2_sat", 64'(stall_count_out[2*16 +: 16]), 64'hFFFF);
`else
        chk("stall_tied0", 64'(stall_count_out), 64'h0);
`endif
        step();
        wr_valid_in = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
